// File: rtl/uart_tx_fifo_if.sv
// Byte-push and status bundle between the UART-to-Wishbone bridge side and the
// transmit FIFO/serializer. The master drives the byte strobe and observes the
// line and FIFO status. The slave is the transmitter.
//
// Handshake: uart_tx_trigger is a valid-only strobe with no ready. A byte is
// accepted on a rising clock edge where uart_tx_trigger is high and
// o_fifo_full was low before that edge. Otherwise the byte is dropped and
// o_overflow latches high. o_fifo_full is advisory back-pressure for a sender
// that chooses to watch it.
interface uart_tx_fifo_if #(
  parameter int FIFO_AW = 3
);
  logic [7:0]       uart_tx_dat;
  logic             uart_tx_trigger;
  logic             o_tx;
  logic             o_busy;
  logic             o_fifo_full;
  logic             o_fifo_empty;
  logic [FIFO_AW:0] o_fifo_level;
  logic             o_overflow;
  logic [1:0]       dbg_state;

  modport master (
    output uart_tx_dat, uart_tx_trigger,
    input  o_tx, o_busy, o_fifo_full, o_fifo_empty, o_fifo_level, o_overflow, dbg_state
  );

  modport slave (
    input  uart_tx_dat, uart_tx_trigger,
    output o_tx, o_busy, o_fifo_full, o_fifo_empty, o_fifo_level, o_overflow, dbg_state
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Transmit-side UART stage. Byte strobes from the bridge are queued in a small
// circular FIFO and serialized as 8N1, LSB first. Back-to-back frames are sent
// with no idle gap while the FIFO still holds data.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_AW      = 3
) (
  input  logic          i_wb_clk,
  input  logic          i_wb_rst_n,
  uart_tx_fifo_if.slave bus
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]    BAUD_RELOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]    CNT_ONE     = CW'(1);
  localparam logic [FIFO_AW:0] PTR_ONE     = {{FIFO_AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  logic [7:0]       mem [DEPTH];
  logic [FIFO_AW:0] wr_ptr;
  logic [FIFO_AW:0] rd_ptr;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             overflow_q;

  state_t           state_q;
  state_t           state_d;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic [2:0]       bit_q;
  logic [2:0]       bit_d;
  logic [7:0]       shift_q;
  logic [7:0]       shift_d;
  logic             tx_q;
  logic             busy_q;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                 (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  // A push is judged on the full flag before the edge, so a same-cycle pop
  // never makes room for it.
  assign push  = bus.uart_tx_trigger && !full;

  // FIFO pointers and the sticky overflow flag.
  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (bus.uart_tx_trigger && full) overflow_q <= 1'b1;
    end
  end

  // FIFO storage. It needs no reset because the pointers gate every read.
  always_ff @(posedge i_wb_clk) begin
    if (push) mem[wr_ptr[FIFO_AW-1:0]] <= bus.uart_tx_dat;
  end

  // Serializer state register.
  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // Serializer next-state: the baud counter counts down and each bit period
  // ends when it reaches zero. The FIFO head is popped on leaving IDLE or at
  // the end of STOP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr[FIFO_AW-1:0]];
          cnt_d   = BAUD_RELOAD;
          bit_d   = 3'd0;
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == '0) begin
          cnt_d   = BAUD_RELOAD;
          bit_d   = 3'd0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          cnt_d   = BAUD_RELOAD;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      STOP: begin
        if (cnt_q == '0) begin
          if (!empty) begin
            pop     = 1'b1;
            shift_d = mem[rd_ptr[FIFO_AW-1:0]];
            cnt_d   = BAUD_RELOAD;
            bit_d   = 3'd0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered line and busy flag. Both trail the state by one cycle, so every
  // bit still lasts exactly CLKS_PER_BIT cycles on the line. Reset forces the
  // line high at once.
  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      tx_q   <= 1'b1;
      busy_q <= 1'b0;
    end else begin
      case (state_q)
        START:   tx_q <= 1'b0;
        DATA:    tx_q <= shift_q[0];
        default: tx_q <= 1'b1;
      endcase
      busy_q <= (state_q != IDLE);
    end
  end

  assign bus.o_tx         = tx_q;
  assign bus.o_busy       = busy_q;
  assign bus.o_fifo_full  = full;
  assign bus.o_fifo_empty = empty;
  assign bus.o_fifo_level = wr_ptr - rd_ptr;
  assign bus.o_overflow   = overflow_q;
  assign bus.dbg_state    = state_q;

endmodule
